// File: rtl/ofm_wr_arb_if.sv
// Write-port bundle between N framed requesters, the OFM write arbiter and the buffer port.
interface ofm_wr_arb_if #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 144,
    parameter int unsigned N  = 2
);
    localparam int unsigned IDW = $clog2(N);

    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_data;
    logic [N-1:0]    m_first;
    logic [N-1:0]    m_last;
    logic [N-1:0]    m_valid;
    logic [N-1:0]    m_ready;

    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_data;
    logic            s_first;
    logic            s_last;
    logic            s_valid;
    logic            s_ready;
    logic [IDW-1:0]  s_id;

    modport master (
        output m_addr, m_data, m_first, m_last, m_valid,
        input  m_ready,
        input  s_addr, s_data, s_first, s_last, s_valid, s_id,
        output s_ready
    );

    modport slave (
        input  m_addr, m_data, m_first, m_last, m_valid,
        output m_ready,
        output s_addr, s_data, s_first, s_last, s_valid, s_id,
        input  s_ready
    );
endinterface

// File: rtl/ofm_wr_arb.sv
// Round-robin arbiter sharing the OFM buffer write port between N framed write streams.
// Grants lock for a whole first..last burst; the winning beat goes through one output register.
module ofm_wr_arb #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 144,
    parameter int unsigned N  = 2
) (
    input  logic        clk,
    input  logic        rst,
    ofm_wr_arb_if.slave bus,
    output logic        busy
);
    localparam int unsigned    IDW     = $clog2(N);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] lk_id_q, lk_id_d;
    logic [AW-1:0]  s_addr_q, s_addr_d;
    logic [DW-1:0]  s_data_q, s_data_d;
    logic           s_first_q, s_first_d;
    logic           s_last_q, s_last_d;
    logic           s_valid_q, s_valid_d;
    logic [IDW-1:0] s_id_q, s_id_d;
    logic           busy_q, busy_d;

    logic [IDW-1:0] gnt_c;
    logic           sel_valid_c;
    logic           adv_c;
    logic           acc_c;
    logic [N-1:0]   m_ready_c;
    logic [AW-1:0]  beat_addr_c;
    logic [DW-1:0]  beat_data_c;
    logic           beat_first_c;
    logic           beat_last_c;

    // Grant: locked owner, or first valid requester scanning from rr_ptr with wrap.
    always_comb begin
        logic [IDW-1:0] idx;
        sel_valid_c = 1'b0;
        gnt_c       = (state_q == LOCK) ? lk_id_q : rr_ptr_q;
        idx         = rr_ptr_q;
        for (int j = 0; j < int'(N); j++) begin
            if ((state_q == IDLE) && !sel_valid_c && bus.m_valid[idx]) begin
                sel_valid_c = 1'b1;
                gnt_c       = idx;
            end
            idx = (idx == LAST_ID) ? '0 : idx + IDW'(1);
        end
    end

    // Handshake and granted-beat mux.
    always_comb begin
        adv_c        = ~s_valid_q | bus.s_ready;
        m_ready_c    = '0;
        beat_addr_c  = '0;
        beat_data_c  = '0;
        beat_first_c = 1'b0;
        beat_last_c  = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            m_ready_c[i] = adv_c & ~rst & (gnt_c == IDW'(i)) & ((state_q == LOCK) | sel_valid_c);
            if (gnt_c == IDW'(i)) begin
                beat_addr_c  = bus.m_addr[i*AW +: AW];
                beat_data_c  = bus.m_data[i*DW +: DW];
                beat_first_c = bus.m_first[i];
                beat_last_c  = bus.m_last[i];
            end
        end
        acc_c = |(m_ready_c & bus.m_valid);
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lk_id_d   = lk_id_q;
        s_addr_d  = s_addr_q;
        s_data_d  = s_data_q;
        s_first_d = s_first_q;
        s_last_d  = s_last_q;
        s_valid_d = s_valid_q;
        s_id_d    = s_id_q;
        if (adv_c) begin
            s_valid_d = 1'b0;
        end
        // A drained beat is replaced in the same cycle, so there is no bubble.
        if (acc_c) begin
            s_valid_d = 1'b1;
            s_addr_d  = beat_addr_c;
            s_data_d  = beat_data_c;
            s_first_d = beat_first_c;
            s_last_d  = beat_last_c;
            s_id_d    = gnt_c;
            if (beat_last_c) begin
                state_d  = IDLE;
                rr_ptr_d = (gnt_c == LAST_ID) ? '0 : gnt_c + IDW'(1);
            end else begin
                state_d = LOCK;
                lk_id_d = gnt_c;
            end
        end
        busy_d = (state_d == LOCK) | s_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            lk_id_q   <= '0;
            s_addr_q  <= '0;
            s_data_q  <= '0;
            s_first_q <= 1'b0;
            s_last_q  <= 1'b0;
            s_valid_q <= 1'b0;
            s_id_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lk_id_q   <= lk_id_d;
            s_addr_q  <= s_addr_d;
            s_data_q  <= s_data_d;
            s_first_q <= s_first_d;
            s_last_q  <= s_last_d;
            s_valid_q <= s_valid_d;
            s_id_q    <= s_id_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.m_ready = m_ready_c;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_data  = s_data_q;
    assign bus.s_first = s_first_q;
    assign bus.s_last  = s_last_q;
    assign bus.s_valid = s_valid_q;
    assign bus.s_id    = s_id_q;
    assign busy        = busy_q;
endmodule
